// File: rtl/btn_fltr_pkg.sv
// Shared constants and event encoding for the multi-channel button debouncer.
package btn_fltr_pkg;

  // Depth of the per-channel input synchronizer.
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_PRESS,
    EV_RELEASE,
    EV_LONG
  } ev_t;

  // All-ones value for a counter of the given width, clamped to 32 bits.
  function automatic logic [31:0] all_ones(input int unsigned width);
    if (width >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/btn_fltr_ch.sv
// One debounce channel: polarity, synchronizer, stability counter, edge pulses and
// an optional hold counter for long-press detection (enabled by BTN_FLTR_LONG_EN).
module btn_fltr_ch
  import btn_fltr_pkg::*;
#(
  parameter int CNTR_WIDTH = 4,
  parameter int ACTIVE_LOW = 0,
  parameter int LONG_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic ce,
  output logic state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam logic [CNTR_WIDTH-1:0] CNT_ONES = CNTR_WIDTH'(all_ones(CNTR_WIDTH));
  localparam logic                  POL      = (ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_out;
  logic [CNTR_WIDTH-1:0]  cnt_reg, cnt_next;
  logic                   state_reg, state_next;
  logic                   press_reg, press_next;
  logic                   release_reg, release_next;

  assign sync_out = sync_reg[SYNC_STAGES-1];

  // Inversion happens before the flops so reset always means "not pressed".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= '0;
    else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw ^ POL};
  end

  always_comb begin
    cnt_next     = cnt_reg;
    state_next   = state_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    if (sync_out == state_reg) begin
      cnt_next = '0;
    end else if (ce) begin
      if (cnt_reg != CNT_ONES) begin
        cnt_next = cnt_reg + CNTR_WIDTH'(1);
      end else begin
        state_next   = sync_out;
        cnt_next     = '0;
        press_next   = sync_out;
        release_next = ~sync_out;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg     <= '0;
      state_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      state_reg   <= state_next;
      press_reg   <= press_next;
      release_reg <= release_next;
    end
  end

  assign state         = state_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;

`ifdef BTN_FLTR_LONG_EN
  localparam logic [LONG_WIDTH-1:0] LONG_ONES = LONG_WIDTH'(all_ones(LONG_WIDTH));

  logic [LONG_WIDTH-1:0] long_cnt_reg, long_cnt_next;
  logic                  long_reg, long_next;

  // Saturation at all-ones is what limits the pulse to once per press.
  always_comb begin
    long_cnt_next = long_cnt_reg;
    long_next     = 1'b0;
    if (!state_reg) begin
      long_cnt_next = '0;
    end else if (ce && (long_cnt_reg != LONG_ONES)) begin
      long_cnt_next = long_cnt_reg + LONG_WIDTH'(1);
      long_next     = (long_cnt_reg == LONG_ONES - LONG_WIDTH'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      long_cnt_reg <= '0;
      long_reg     <= 1'b0;
    end else begin
      long_cnt_reg <= long_cnt_next;
      long_reg     <= long_next;
    end
  end

  assign long_pulse = long_reg;
`else
  // LONG_WIDTH has no effect without the hold counter.
  logic unused_long;
  assign unused_long = (LONG_WIDTH > 0);
  assign long_pulse  = 1'b0;
`endif

endmodule

// File: rtl/btn_fltr_multi.sv
// N_CH-channel button debouncer with an aggregate any-press pulse.
// Long-press detection is compiled in with BTN_FLTR_LONG_EN.
module btn_fltr_multi
  import btn_fltr_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNTR_WIDTH = 4,
  parameter int ACTIVE_LOW = 0,
  parameter int LONG_WIDTH = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] BTN_IN,
  input  logic            CE,
  output logic [N_CH-1:0] BTN_OUT,
  output logic [N_CH-1:0] BTN_PRESS,
  output logic [N_CH-1:0] BTN_RELEASE,
  output logic [N_CH-1:0] BTN_LONG,
  output logic            ANY_PRESS
);

  logic any_press_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      btn_fltr_ch #(
        .CNTR_WIDTH (CNTR_WIDTH),
        .ACTIVE_LOW (ACTIVE_LOW),
        .LONG_WIDTH (LONG_WIDTH)
      ) u_ch (
        .clk           (CLK),
        .rst           (RST),
        .raw           (BTN_IN[gi]),
        .ce            (CE),
        .state         (BTN_OUT[gi]),
        .press_pulse   (BTN_PRESS[gi]),
        .release_pulse (BTN_RELEASE[gi]),
        .long_pulse    (BTN_LONG[gi])
      );
    end
  endgenerate

  // Registered so simultaneous presses still collapse into one clean pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) any_press_reg <= 1'b0;
    else     any_press_reg <= |BTN_PRESS;
  end

  assign ANY_PRESS = any_press_reg;

endmodule

// File: tb/tb_btn_fltr_multi.sv
// Directed bench for btn_fltr_multi (N_CH=4, CNTR_WIDTH=2, LONG_WIDTH=3) with an event scoreboard.
`timescale 1ns/1ps
module tb_btn_fltr_multi;
  import btn_fltr_pkg::*;

  localparam int CW       = 2;
  localparam int LW       = 3;
  localparam int DEB      = 2 + (1 << CW);
  localparam int LONG_DLY = (1 << LW) - 1;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CE;
  logic [3:0] BTN_IN;
  logic [3:0] BTN_OUT, BTN_PRESS, BTN_RELEASE, BTN_LONG;
  logic       ANY_PRESS;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
  } exp_t;

  exp_t ev_q[4][$];
  int   any_q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  btn_fltr_multi #(
    .N_CH       (4),
    .CNTR_WIDTH (CW),
    .ACTIVE_LOW (0),
    .LONG_WIDTH (LW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .BTN_IN      (BTN_IN),
    .CE          (CE),
    .BTN_OUT     (BTN_OUT),
    .BTN_PRESS   (BTN_PRESS),
    .BTN_RELEASE (BTN_RELEASE),
    .BTN_LONG    (BTN_LONG),
    .ANY_PRESS   (ANY_PRESS)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_ev(input ev_t k, input int dly, input logic [3:0] mask);
    ev_q[int'(k)].push_back('{cyc + dly, mask});
    if (k == EV_PRESS) any_q.push_back(cyc + dly + 1);
  endtask

  task automatic scan_kind(input ev_t k, input logic [3:0] vec, input string name);
    exp_t e;
    if (ev_q[int'(k)].size() != 0 && ev_q[int'(k)][0].cyc < cyc) begin
      e = ev_q[int'(k)].pop_front();
      chk({"missed_", name}, cyc, e.cyc);
    end
    if (vec != 4'd0) begin
      if (ev_q[int'(k)].size() == 0) begin
        chk({"unexpected_", name}, {28'd0, vec}, 32'd0);
      end else begin
        e = ev_q[int'(k)].pop_front();
        chk({name, "_cycle"}, cyc, e.cyc);
        chk({name, "_mask"}, {28'd0, vec}, {28'd0, e.mask});
      end
    end
  endtask

  task automatic scan_any();
    int c;
    if (any_q.size() != 0 && any_q[0] < cyc) begin
      c = any_q.pop_front();
      chk("missed_any_press", cyc, c);
    end
    if (ANY_PRESS !== 1'b0) begin
      if (any_q.size() == 0) begin
        chk("unexpected_any_press", {31'd0, ANY_PRESS}, 32'd0);
      end else begin
        c = any_q.pop_front();
        chk("any_press_cycle", cyc, c);
      end
    end
  endtask

  // One clock: count the edge, then inspect outputs on the falling edge.
  task automatic tick();
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    scan_kind(EV_PRESS, BTN_PRESS, "press");
    scan_kind(EV_RELEASE, BTN_RELEASE, "release");
    scan_kind(EV_LONG, BTN_LONG, "long");
    scan_any();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic press_release(input logic [3:0] mask);
    BTN_IN = BTN_IN | mask;
    expect_ev(EV_PRESS, DEB, mask);
    run(DEB);
    chk("out_pressed", {28'd0, BTN_OUT & mask}, {28'd0, mask});
    BTN_IN = BTN_IN & ~mask;
    expect_ev(EV_RELEASE, DEB, mask);
    run(DEB);
    chk("out_released", {28'd0, BTN_OUT & mask}, 32'd0);
    run(2);
  endtask

  initial begin
    RST    = 1'b1;
    CE     = 1'b1;
    BTN_IN = 4'hF;

    // Reset with all inputs high, then release: one simultaneous press.
    repeat (3) begin
      tick();
      chk("reset_outputs", {15'd0, BTN_OUT, BTN_PRESS, BTN_RELEASE, BTN_LONG, ANY_PRESS}, 32'd0);
    end
    RST = 1'b0;
    expect_ev(EV_PRESS, DEB, 4'hF);
    run(DEB - 1);
    chk("out_before_window", {28'd0, BTN_OUT}, 32'd0);
    run(1);
    chk("out_after_window", {28'd0, BTN_OUT}, 32'hF);
    BTN_IN = 4'h0;
    expect_ev(EV_RELEASE, DEB, 4'hF);
    run(DEB + 2);

    // Clean press/release on channel 0.
    press_release(4'b0001);

    // Bouncing channel 1: no pulses until the input settles.
    for (int i = 0; i < 20; i++) begin
      BTN_IN[1] = (i % 2 == 0);
      run(2);
    end
    chk("bounce_out", {31'd0, BTN_OUT[1]}, 32'd0);
    BTN_IN[1] = 1'b1;
    expect_ev(EV_PRESS, DEB, 4'b0010);
    run(DEB);
    BTN_IN[1] = 1'b0;
    expect_ev(EV_RELEASE, DEB, 4'b0010);
    run(DEB + 2);

    // CE held low freezes channel 2; then one CE tick every 4 clocks.
    CE        = 1'b0;
    BTN_IN[2] = 1'b1;
    run(100);
    chk("ce_low_out", {31'd0, BTN_OUT[2]}, 32'd0);
    expect_ev(EV_PRESS, 4 * ((1 << CW) - 1) + 1, 4'b0100);
    for (int k = 0; k < 13; k++) begin
      CE = (k % 4 == 0);
      tick();
    end
    CE = 1'b1;
    chk("ce_tick_out", {31'd0, BTN_OUT[2]}, 32'd1);
    BTN_IN[2] = 1'b0;
    expect_ev(EV_RELEASE, DEB, 4'b0100);
    run(DEB + 2);

    // Simultaneous presses on channels 0 and 3.
    press_release(4'b1001);

    // Reset while channel 0 is pressed and channel 1 is mid-window.
    BTN_IN[0] = 1'b1;
    expect_ev(EV_PRESS, DEB, 4'b0001);
    run(DEB);
    BTN_IN[1] = 1'b1;
    run(3);
    #2 RST = 1'b1;
    #1 chk("async_reset_out", {28'd0, BTN_OUT}, 32'd0);
    run(2);
    RST = 1'b0;
    expect_ev(EV_PRESS, DEB, 4'b0011);
    run(DEB);
    BTN_IN[1:0] = 2'b00;
    expect_ev(EV_RELEASE, DEB, 4'b0011);
    run(DEB + 2);

    // Long hold on channel 0, release, press again.
    BTN_IN[0] = 1'b1;
    expect_ev(EV_PRESS, DEB, 4'b0001);
`ifdef BTN_FLTR_LONG_EN
    expect_ev(EV_LONG, DEB + LONG_DLY, 4'b0001);
`endif
    run(30);
    BTN_IN[0] = 1'b0;
    expect_ev(EV_RELEASE, DEB, 4'b0001);
    run(10);
    BTN_IN[0] = 1'b1;
    expect_ev(EV_PRESS, DEB, 4'b0001);
`ifdef BTN_FLTR_LONG_EN
    expect_ev(EV_LONG, DEB + LONG_DLY, 4'b0001);
`endif
    run(DEB + LONG_DLY + 1);
    BTN_IN[0] = 1'b0;
    expect_ev(EV_RELEASE, DEB, 4'b0001);
    run(DEB + 2);

    chk("queues_drained",
        ev_q[1].size() + ev_q[2].size() + ev_q[3].size() + any_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
